// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer and key-schedule unit.
// Holds the FSM states, the encrypt rotation schedule and the round/mode -> shift lookup.
package des_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SBOX,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam int SBOX_SLOTS = 8;

  // Index 0 is round 0; the concatenation below is written from round 15 down to round 0.
  localparam logic [15:0][1:0] ENC_SHIFT_SCHED = {
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1
  };

  // Decrypt rotates right and walks the encrypt schedule backwards, with no rotation in round 0.
  function automatic logic [1:0] shift_amt(input logic [3:0] rnd, input logic mode);
    logic [3:0] idx;
    idx = 4'(5'd16 - {1'b0, rnd});
    if (!mode) begin
      return ENC_SHIFT_SCHED[rnd];
    end else if (rnd == 4'd0) begin
      return 2'd0;
    end else begin
      return ENC_SHIFT_SCHED[idx];
    end
  endfunction

endpackage

// File: rtl/des_shift_sched.sv
// Combinational key rotation schedule: round index and mode give rotation amount and direction.
module des_shift_sched
  import des_pkg::*;
(
  input  logic [3:0] rnd,
  input  logic       mode,
  output logic [1:0] amt,
  output logic       dir
);

  assign amt = shift_amt(rnd, mode);
  assign dir = mode;

endmodule

// File: rtl/des_round_ctrl.sv
// DES round sequencer: accepts a block job, steps the Feistel rounds (optionally with a
// time-shared S-box), triggers the final permutation and hands the result out via valid/ready.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int SERIAL_SBOX = 0,
  parameter int N_ROUNDS    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_mode,
  output logic       in_ready,
  output logic       load_en,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic [1:0] key_shift_amt,
  output logic       key_shift_dir,
  output logic [2:0] sbox_sel,
  output logic       sbox_cap_en,
  output logic       fp_en,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam logic [3:0] LAST_ROUND = 4'(N_ROUNDS - 1);
  localparam logic [2:0] LAST_SLOT  = 3'(SBOX_SLOTS - 1);
  localparam bit         SERIAL     = (SERIAL_SBOX != 0);

  state_t     state_reg;
  logic       mode_reg;
  logic [1:0] sched_amt;
  logic       sched_dir;
  logic       in_round;

  assign load_en = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      mode_reg    <= 1'b0;
      round_idx   <= 4'd0;
      sbox_sel    <= 3'd0;
      round_en    <= 1'b0;
      sbox_cap_en <= 1'b0;
      fp_en       <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      in_ready    <= 1'b1;
    end else begin
      round_en    <= 1'b0;
      sbox_cap_en <= 1'b0;
      fp_en       <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            mode_reg    <= in_mode;
            round_idx   <= 4'd0;
            sbox_sel    <= 3'd0;
            busy        <= 1'b1;
            in_ready    <= 1'b0;
            sbox_cap_en <= 1'b1;
            if (SERIAL) begin
              state_reg <= SBOX;
            end else begin
              state_reg <= ROUND;
              round_en  <= 1'b1;
            end
          end
        end
        SBOX: begin
          if (sbox_sel == LAST_SLOT) begin
            sbox_sel  <= 3'd0;
            state_reg <= ROUND;
            round_en  <= 1'b1;
          end else begin
            sbox_sel    <= sbox_sel + 3'd1;
            sbox_cap_en <= 1'b1;
          end
        end
        ROUND: begin
          if (round_idx == LAST_ROUND) begin
            state_reg <= FINAL;
            fp_en     <= 1'b1;
          end else begin
            round_idx   <= round_idx + 4'd1;
            sbox_cap_en <= 1'b1;
            if (SERIAL) begin
              state_reg <= SBOX;
            end else begin
              round_en <= 1'b1;
            end
          end
        end
        FINAL: begin
          state_reg <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  des_shift_sched u_sched (
    .rnd  (round_idx),
    .mode (mode_reg),
    .amt  (sched_amt),
    .dir  (sched_dir)
  );

  // Rotation controls are only meaningful while a round is in flight; idle shows no rotation.
  assign in_round      = (state_reg == SBOX) || (state_reg == ROUND);
  assign key_shift_amt = in_round ? sched_amt : 2'd0;
  assign key_shift_dir = in_round ? sched_dir : 1'b0;

endmodule
